// File: rtl/seg_scan.sv
// seg_scan: 6-digit common-anode 7-segment scanner for the stopwatch BCD time word.
// A slot timer steps a digit index. The BCD word is captured into a shadow register once
// per frame, so a single frame never mixes old and new digits. Each slot begins with a
// short all-off dead time to suppress ghosting between digits.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zeros on digits 5..3).
module seg_scan #(
  parameter logic [15:0] CNT_SCAN = 16'd49_999,
  parameter logic [7:0]  DEAD_CYC = 8'd50,
  parameter logic [5:0]  DP_MASK  = 6'b010100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] din,
  output logic [7:0]  seg,
  output logic [5:0]  sel
);

  logic [15:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] shadow_q, shadow_d;
  logic [7:0]  seg_q, seg_d;
  logic [5:0]  sel_q, sel_d;

  logic        tick_s;
  logic        dead_s;
  logic [3:0]  nib_s;
  logic [5:0]  sel_act_s;
  logic        dp_en_s;
  logic        blank_lz_s;
  logic        blank_s;

  // Segment pattern {g,f,e,d,c,b,a}, active low; non-BCD codes decode to all off.
  function automatic logic [6:0] dec7(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'd0:    r = 7'h40;
      4'd1:    r = 7'h79;
      4'd2:    r = 7'h24;
      4'd3:    r = 7'h30;
      4'd4:    r = 7'h19;
      4'd5:    r = 7'h12;
      4'd6:    r = 7'h02;
      4'd7:    r = 7'h78;
      4'd8:    r = 7'h00;
      4'd9:    r = 7'h10;
      default: r = 7'h7f;
    endcase
    return r;
  endfunction

  // Slot timer, digit index and the frame-end shadow capture.
  always_comb begin
    tick_s   = (timer_q == CNT_SCAN);
    timer_d  = timer_q + 16'd1;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (tick_s) begin
      timer_d = 16'd0;
      if (idx_q == 3'd5) begin
        idx_d    = 3'd0;
        shadow_d = din;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Select the current digit's nibble, its enable pattern and its decimal-point flag.
  always_comb begin
    nib_s     = 4'hf;
    sel_act_s = 6'h3f;
    dp_en_s   = 1'b0;
    case (idx_q)
      3'd0: begin nib_s = shadow_q[3:0];   sel_act_s = 6'b111110; dp_en_s = DP_MASK[0]; end
      3'd1: begin nib_s = shadow_q[7:4];   sel_act_s = 6'b111101; dp_en_s = DP_MASK[1]; end
      3'd2: begin nib_s = shadow_q[11:8];  sel_act_s = 6'b111011; dp_en_s = DP_MASK[2]; end
      3'd3: begin nib_s = shadow_q[15:12]; sel_act_s = 6'b110111; dp_en_s = DP_MASK[3]; end
      3'd4: begin nib_s = shadow_q[19:16]; sel_act_s = 6'b101111; dp_en_s = DP_MASK[4]; end
      3'd5: begin nib_s = shadow_q[23:20]; sel_act_s = 6'b011111; dp_en_s = DP_MASK[5]; end
      default: begin nib_s = 4'hf; sel_act_s = 6'h3f; dp_en_s = 1'b0; end
    endcase
  end

  // Leading-zero blanking of the minutes/seconds-tens digits, judged on the shadow word only.
  always_comb begin
    blank_lz_s = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_q)
      3'd5:    blank_lz_s = (shadow_q[23:20] == 4'd0);
      3'd4:    blank_lz_s = (shadow_q[23:16] == 8'd0);
      3'd3:    blank_lz_s = (shadow_q[23:12] == 12'd0);
      default: blank_lz_s = 1'b0;
    endcase
`else
    blank_lz_s = 1'b0;
`endif
  end

  // Next output values: dark during dead time, otherwise one enabled digit with its pattern.
  always_comb begin
    dead_s  = (timer_q < {8'd0, DEAD_CYC});
    blank_s = (nib_s > 4'd9) || blank_lz_s;
    seg_d   = 8'hff;
    sel_d   = 6'h3f;
    if (dead_s) begin
      seg_d = 8'hff;
      sel_d = 6'h3f;
    end else begin
      sel_d = sel_act_s;
      if (blank_s) begin
        seg_d = 8'hff;
      end else begin
        seg_d = {~dp_en_s, dec7(nib_s)};
      end
    end
  end

  // State and registered display outputs; async reset blanks everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q  <= 16'd0;
      idx_q    <= 3'd0;
      shadow_q <= 24'hffffff;
      seg_q    <= 8'hff;
      sel_q    <= 6'h3f;
    end else begin
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
    end
  end

  assign seg = seg_q;
  assign sel = sel_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with a 10-cycle slot (2 dead cycles) and a 60-cycle frame.
// cyc counts rising edges since reset release; the sample taken after edge n shows the
// state from after edge n-1: slot position t=(n-1)%10 and digit i=((n-1)/10)%6.
module tb_seg_scan;

  logic        clk;
  logic        rst_n;
  logic [23:0] din;
  logic [7:0]  seg;
  logic [5:0]  sel;

  int errors = 0;
  int checks = 0;
  int cyc;

  seg_scan #(
    .CNT_SCAN(16'd9),
    .DEAD_CYC(8'd2),
    .DP_MASK (6'b010100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .seg  (seg),
    .sel  (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc=%0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to the falling edge where cyc == n (bounded).
  task automatic goto(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) chk("goto_timeout", cyc, n);
  endtask

  function automatic logic [5:0] exp_sel(input int n);
    int t;
    int i;
    t = (n - 1) % 10;
    i = ((n - 1) / 10) % 6;
    if (t < 2) return 6'h3f;
    return ~(6'b000001 << i);
  endfunction

  initial begin
    rst_n = 1'b0;
    din   = 24'h123456;
    repeat (3) @(negedge clk);
    chk("rst_seg", seg, 8'hff);
    chk("rst_sel", sel, 6'h3f);
    rst_n = 1'b1;

    // Frame 0: shadow still blank, every active slot dark but scanning.
    for (int i = 0; i < 6; i++) begin
      goto(10 * i + 6);
      chk("f0_seg", seg, 8'hff);
      chk("f0_sel", sel, exp_sel(10 * i + 6));
    end

    // Frame 1: full slot timing sweep plus decoded 123456.
    for (int n = 61; n <= 120; n++) begin
      goto(n);
      chk("f1_sel", sel, exp_sel(n));
      if (((n - 1) % 10) < 2) chk("f1_dead_seg", seg, 8'hff);
      case (n)
        66:  chk("f1_d0", seg, 8'h82);
        76:  chk("f1_d1", seg, 8'h92);
        86:  chk("f1_d2", seg, 8'h19);
        96:  chk("f1_d3", seg, 8'hb0);
        106: chk("f1_d4", seg, 8'h24);
        116: chk("f1_d5", seg, 8'hf9);
        default: ;
      endcase
      if (n == 100) din = 24'h111111;
    end

    // Frame 2: all '1'; mid-frame change to 999999 must not show until frame 3.
    goto(126); chk("f2_d0", seg, 8'hf9);
    goto(145); chk("f2_d2", seg, 8'h79);
    goto(146); din = 24'h999999;
    goto(156); chk("f2_d3_hold", seg, 8'hf9);
    goto(166); chk("f2_d4_hold", seg, 8'h79);
    goto(176); chk("f2_d5_hold", seg, 8'hf9);

    // Frame 3: all '9'.
    goto(186); chk("f3_d0", seg, 8'h90);
    goto(206); chk("f3_d2", seg, 8'h10);
    goto(226); chk("f3_d4", seg, 8'h10);
    goto(236); chk("f3_d5", seg, 8'h90);
    din = 24'hffffff;

    // Frame 4: all-F word -> dark display, sel still scanning.
    for (int i = 0; i < 6; i++) begin
      goto(246 + 10 * i);
      chk("f4_seg", seg, 8'hff);
      chk("f4_sel", sel, exp_sel(246 + 10 * i));
    end
    din = 24'h000512;

    // Frame 5: 000512 with or without leading-zero blanking.
    goto(306); chk("f5_d0", seg, 8'ha4);
    goto(316); chk("f5_d1", seg, 8'hf9);
    goto(326); chk("f5_d2", seg, 8'h12);
`ifdef LEADING_ZERO_BLANK_EN
    goto(336); chk("f5_d3", seg, 8'hff);
    goto(346); chk("f5_d4", seg, 8'hff);
    goto(356); chk("f5_d5", seg, 8'hff);
`else
    goto(336); chk("f5_d3", seg, 8'hc0);
    goto(346); chk("f5_d4", seg, 8'h40);
    goto(356); chk("f5_d5", seg, 8'hc0);
`endif

    // Mid-slot reset at digit 3 of frame 6.
    goto(396);
    chk("pre_rst_sel", sel, 6'h37);
    rst_n = 1'b0;
    #1;
    chk("midrst_seg", seg, 8'hff);
    chk("midrst_sel", sel, 6'h3f);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    goto(1); chk("rel_dead1_sel", sel, 6'h3f);
    goto(2); chk("rel_dead2_sel", sel, 6'h3f);
             chk("rel_dead2_seg", seg, 8'hff);
    goto(3); chk("rel_d0_sel", sel, 6'h3e);
    goto(6); chk("rel_blank_seg", seg, 8'hff);
             chk("rel_d0_sel2", sel, 6'h3e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
